// File: rtl/tone_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_seq_pkg
// Purpose  : Shared types and default widths for the tone note sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tone_seq_pkg;

  localparam int c_div_w_default     = 16;
  localparam int c_dur_w_default     = 4;
  localparam int c_notes_default     = 16;
  localparam int c_tick_div_default  = 250000;
  localparam int c_gap_ticks_default = 1;

  // Playback state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Table entry at default widths; duration sits in the LSBs
  typedef struct packed {
    logic [c_div_w_default-1:0] div;
    logic [c_dur_w_default-1:0] dur;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/tone_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tone_tick_gen
// Purpose  : Free-running prescaler; o_tick is high for one cycle every
//            TICK_DIV cycles. i_clear restarts the count synchronously.
// Revision : 1.0 - initial release
// ============================================================================
module tone_tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int                c_cw   = $clog2(TICK_DIV);
  localparam logic [c_cw-1:0]   c_last = c_cw'(TICK_DIV - 1);

  logic [c_cw-1:0] r_cnt;

  // Count 0..TICK_DIV-1, restarting on clear or terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Purpose  : Plays a programmable note table into the tone generator, holding
//            each entry for dur ticks followed by a fixed silent gap.
//            Optional looping playback is enabled by defining TONESEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 4,
  parameter int NOTES     = 16,
  parameter int TICK_DIV  = 250000,
  parameter int GAP_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [DIV_W+DUR_W-1:0]   wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [DIV_W-1:0]         tone_div,
  output logic                     tone_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] cur_idx
);

  import tone_seq_pkg::*;

  localparam int c_idx_w    = $clog2(NOTES);
  localparam int c_gap_w    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int c_cnt_w    = (DUR_W > c_gap_w) ? DUR_W : c_gap_w;
  localparam int c_gap_last = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NOTES - 1);

  logic [DIV_W+DUR_W-1:0] r_table [NOTES];

  state_t             r_state;
  logic [DUR_W-1:0]   r_dur;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic [DIV_W-1:0]   r_tone_div;
  logic               r_tone_en;
  logic               r_busy;
  logic               r_done;

  logic                   w_tick;
  logic                   w_clear;
  logic                   w_loop_req;
  logic                   w_from_idle;
  logic                   w_note_end;
  logic                   w_gap_end;
  logic                   w_advance;
  logic                   w_to_gap;
  logic [c_idx_w-1:0]     w_nxt_idx;
  logic [DIV_W+DUR_W-1:0] w_nxt_entry;
  logic                   w_seq_end;
  logic                   w_loop_go;
  logic                   w_ld;
  logic [c_idx_w-1:0]     w_ld_idx;
  logic [DIV_W+DUR_W-1:0] w_ld_entry;
  logic [DIV_W-1:0]       w_ld_div;
  logic [DUR_W-1:0]       w_ld_dur;

`ifdef TONESEQ_LOOP_EN
  assign w_loop_req = loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = loop;
  assign w_loop_req    = 1'b0;
`endif

  tone_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // Host table writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // Event decode: note/gap expiry and which entry (if any) loads next
  assign w_from_idle = (r_state == IDLE) && start;
  assign w_note_end  = (r_state == NOTE) && w_tick &&
                       ((r_cnt + c_cnt_w'(1)) == c_cnt_w'(r_dur));
  assign w_gap_end   = (r_state == GAP) && w_tick &&
                       (r_cnt == c_cnt_w'(c_gap_last));
  assign w_advance   = (w_note_end && (GAP_TICKS == 0)) || w_gap_end;
  assign w_to_gap    = w_note_end && (GAP_TICKS != 0);

  assign w_nxt_idx   = w_from_idle ? '0 : r_idx + 1'b1;
  assign w_nxt_entry = r_table[w_nxt_idx];

  // A zero duration or running off the last entry terminates the sequence
  assign w_seq_end = (w_from_idle && (w_nxt_entry[DUR_W-1:0] == '0)) ||
                     (w_advance && ((r_idx == c_last_idx) ||
                                    (w_nxt_entry[DUR_W-1:0] == '0)));
  assign w_loop_go = w_seq_end && w_advance && w_loop_req &&
                     (r_table[0][DUR_W-1:0] != '0);
  assign w_ld      = ((w_from_idle || w_advance) && !w_seq_end) || w_loop_go;
  assign w_ld_idx  = w_loop_go ? '0 : w_nxt_idx;

  assign w_ld_entry = r_table[w_ld_idx];
  assign w_ld_div   = w_ld_entry[DIV_W+DUR_W-1:DUR_W];
  assign w_ld_dur   = w_ld_entry[DUR_W-1:0];

  // Prescaler is held clear while idle and restarted on every phase change
  assign w_clear = (r_state == IDLE) || w_ld || w_to_gap;

  // Playback state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dur      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_tone_div <= '0;
      r_tone_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_tone_div <= '0;
        r_tone_en  <= 1'b0;
        r_busy     <= 1'b0;
      end else if (w_ld) begin
        r_state    <= NOTE;
        r_idx      <= w_ld_idx;
        r_dur      <= w_ld_dur;
        r_cnt      <= '0;
        r_tone_div <= w_ld_div;
        r_tone_en  <= (w_ld_div != '0);
        r_busy     <= 1'b1;
        r_done     <= w_loop_go;
      end else if (w_seq_end) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_tone_div <= '0;
        r_tone_en  <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
      end else if (w_to_gap) begin
        r_state   <= GAP;
        r_cnt     <= '0;
        r_tone_en <= 1'b0;
      end else if ((r_state != IDLE) && w_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tone_div = r_tone_div;
  assign tone_en  = r_tone_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cur_idx  = r_idx;

endmodule
`default_nettype wire
